// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares the 4x8 memory_system between two requesters:
//     req 0 = switch/button front end, req 1 = auto-fill/pattern engine.
//   One transaction at a time. The block drives mem_addr/mem_data with setup
//   and hold around a level-enabled mem_store pulse. It samples the readback
//   and returns it to the granted requester with a one-cycle ack.
//   Optional feature macro: MEM_ARB_VERIFY_EN
//     Adds a VERIFY state after HOLD. This state compares the readback with
//     the written byte and sets a sticky err flag on mismatch.
module mem_access_arbiter #(
  parameter int STORE_CYCLES = 2,     // mem_store pulse width in clocks, 1..15
  parameter bit RR_EN        = 1'b1   // 1 = round-robin, 0 = fixed priority (req 0)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       err,
  output logic [1:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_store,
  input  logic [7:0] mem_q
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STORE  = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] SAMPLE = 3'd4;
  localparam logic [2:0] ACK    = 3'd5;
`ifdef MEM_ARB_VERIFY_EN
  localparam logic [2:0] VERIFY = 3'd6;
`endif

  // The counter is loaded with one less than the width, so that exit happens on count zero.
  localparam logic [3:0] CNT_LOAD = 4'(STORE_CYCLES - 1);

  logic [2:0] r_state;
  logic       r_gnt;        // granted requester of the transaction in flight
  logic       r_last;       // requester granted most recently (round-robin pointer)
  logic       r_we;
  logic [7:0] r_wdata;
  logic [3:0] r_cnt;
  logic [1:0] r_ack;
  logic [7:0] r_rdata;
  logic       r_busy;
  logic [1:0] r_mem_addr;
  logic [7:0] r_mem_data;
  logic       r_mem_store;
`ifdef MEM_ARB_VERIFY_EN
  logic       r_err;
`endif

  logic       w_any;
  logic       w_win;
  logic [1:0] w_gnt_oh;
  logic [2:0] w_next;

  assign w_any    = |req;
  assign w_gnt_oh = r_gnt ? 2'b10 : 2'b01;

  // Arbitration: a lone request wins. On contention, round-robin picks the requester not granted last.
  always_comb begin
    w_win = req[1];
    if (req == 2'b11) begin
      w_win = RR_EN ? ~r_last : 1'b0;
    end
  end

  // Next-state selection for the transaction sequencer
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:   w_next = w_any ? SETUP : IDLE;
      SETUP:  w_next = r_we ? STORE : SAMPLE;
      STORE:  w_next = (r_cnt == 4'd0) ? HOLD : STORE;
`ifdef MEM_ARB_VERIFY_EN
      HOLD:   w_next = VERIFY;
      VERIFY: w_next = ACK;
`else
      HOLD:   w_next = ACK;
`endif
      SAMPLE: w_next = ACK;
      ACK:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Sequencer state, grant capture and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;   // requester 0 is preferred on the first contention
      r_we        <= 1'b0;
      r_wdata     <= 8'h00;
      r_cnt       <= 4'd0;
      r_ack       <= 2'b00;
      r_rdata     <= 8'h00;
      r_busy      <= 1'b0;
      r_mem_addr  <= 2'd0;
      r_mem_data  <= 8'h00;
      r_mem_store <= 1'b0;
`ifdef MEM_ARB_VERIFY_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != IDLE);
      r_ack   <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            // Capture the request here. The bus pins change only on this edge.
            r_gnt      <= w_win;
            r_last     <= w_win;
            r_we       <= w_win ? we[1] : we[0];
            r_wdata    <= w_win ? wdata1 : wdata0;
            r_mem_addr <= w_win ? addr1 : addr0;
            r_mem_data <= w_win ? wdata1 : wdata0;
          end
        end
        SETUP: begin
          if (r_we) begin
            r_mem_store <= 1'b1;
            r_cnt       <= CNT_LOAD;
          end
        end
        STORE: begin
          if (r_cnt == 4'd0) begin
            r_mem_store <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
`ifndef MEM_ARB_VERIFY_EN
          r_ack   <= w_gnt_oh;
          r_rdata <= r_wdata;
`endif
        end
`ifdef MEM_ARB_VERIFY_EN
        VERIFY: begin
          if (mem_q != r_wdata) begin
            r_err <= 1'b1;
          end
          r_rdata <= mem_q;
          r_ack   <= w_gnt_oh;
        end
`endif
        SAMPLE: begin
          r_rdata <= mem_q;
          r_ack   <= w_gnt_oh;
        end
        default: begin
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_store = r_mem_store;
`ifdef MEM_ARB_VERIFY_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
//   Bench for mem_access_arbiter, with a behavioural memory_system attached.
//   A transaction-level model predicts, for each transaction:
//     - the grant winner
//     - the ack latency
//     - the store pulse width
//     - the returned byte
//   Macro MEM_ARB_VERIFY_EN selects the verify build.
module tb_mem_access_arbiter;

  localparam int SC = 2;
  localparam bit RR = 1'b1;
`ifdef MEM_ARB_VERIFY_EN
  localparam int WLAT = SC + 3;
`else
  localparam int WLAT = SC + 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] we;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy, err;
  logic [1:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_store;
  logic [7:0] mem_q;

  logic [7:0] tbmem [4] = '{default: 8'h00};
  bit         force0 = 1'b0;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl [4];
  bit         last;

  mem_access_arbiter #(.STORE_CYCLES(SC), .RR_EN(RR)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_store(mem_store), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level-enabled byte stores of the memory_system
  always @(posedge clk) if (mem_store) tbmem[mem_addr] <= mem_data;
  assign mem_q = force0 ? 8'h00 : tbmem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input bit who, input bit w, input logic [1:0] a, input logic [7:0] d);
    if (who) begin we[1] = w; addr1 = a; wdata1 = d; end
    else     begin we[0] = w; addr0 = a; wdata0 = d; end
  endtask

  // Run transactions until every requester in pend_in has been acked
  task automatic serve(input logic [1:0] pend_in, input bit drop_early);
    logic [1:0] pend;
    bit         win;
    bit         w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    int         k, lat, st;
    pend = pend_in;
    while (pend != 2'b00) begin
      req = pend;
      k = 0;
      while (busy !== 1'b0 && k < 50) begin @(posedge clk); #1; k++; end
      chk("idle_wait", (k < 50), 1);
      if (pend == 2'b11) win = RR ? ~last : 1'b0;
      else               win = pend[1];
      last = win;
      w = we[win];
      a = win ? addr1 : addr0;
      d = win ? wdata1 : wdata0;
      @(posedge clk); #1;
      chk("busy_grant", busy, 1);
      if (drop_early) req[win] = 1'b0;
      lat = 0; st = 0;
      while (ack == 2'b00 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (mem_store) st++;
      end
      exp_rd = w ? (force0 ? 8'h00 : d) : mdl[a];
      chk("ack_onehot", ack, win ? 2'b10 : 2'b01);
      chk("latency", lat, w ? WLAT : 2);
      chk("store_width", st, w ? SC : 0);
      chk("rdata", rdata, exp_rd);
      chk("mem_addr", mem_addr, a);
      if (w) mdl[a] = d;
      pend[win] = 1'b0;
      req[win]  = 1'b0;
      @(posedge clk); #1;
      chk("ack_pulse", ack, 2'b00);
      chk("busy_idle", busy, 0);
    end
  endtask

  task automatic reset_mid_store();
    int k;
    set_op(0, 1'b1, 2'd3, 8'h77);
    req = 2'b01;
    @(posedge clk); #1;
    k = 0;
    while (mem_store !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    chk("store_seen", (k < 10), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_store", mem_store, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 2'b00);
    req = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_ack", ack, 2'b00);
    end
    rst_n = 1'b1;
    last = 1'b1;
    mdl[3] = 8'h77;   // store was high across an edge before the abort
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = 2'd0; addr1 = 2'd0; wdata0 = 8'h00; wdata1 = 8'h00;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", ack, 2'b00);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    chk("reset_store", mem_store, 0);
    chk("reset_maddr", mem_addr, 2'd0);
    chk("reset_mdata", mem_data, 8'h00);
    rst_n = 1'b1;

    // Write A5 to byte 2, read it back, check the other bytes are untouched
    set_op(0, 1'b1, 2'd2, 8'hA5); serve(2'b01, 1'b0);
    set_op(0, 1'b0, 2'd2, 8'h00); serve(2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_op(0, 1'b0, 2'(i), 8'h00); serve(2'b01, 1'b0);
    end

    // Contention: both requesters write to byte 1
    for (int r = 0; r < 2; r++) begin
      set_op(0, 1'b1, 2'd1, 8'h11);
      set_op(1, 1'b1, 2'd1, 8'h22);
      serve(2'b11, 1'b0);
    end

    // Fill all bytes from requester 1, read them back from requester 0
    for (int i = 0; i < 4; i++) begin
      set_op(1, 1'b1, 2'(i), 8'h10 + 8'(i)); serve(2'b10, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      set_op(0, 1'b0, 2'(i), 8'h00); serve(2'b01, 1'b0);
    end

    // Request dropped right after grant still completes
    set_op(1, 1'b1, 2'd0, 8'h3C); serve(2'b10, 1'b1);

    // Reset in the middle of a store, then confirm the abort left no ack
    reset_mid_store();
    set_op(0, 1'b0, 2'd3, 8'h00); serve(2'b01, 1'b0);
    set_op(1, 1'b1, 2'd2, 8'h44);
    set_op(0, 1'b1, 2'd1, 8'h55);
    serve(2'b11, 1'b0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      logic [1:0] p;
      bit         de;
      p = 2'($urandom_range(1, 3));
      set_op(0, 1'($urandom), 2'($urandom), 8'($urandom));
      set_op(1, 1'($urandom), 2'($urandom), 8'($urandom));
      de = (p != 2'b11) && ($urandom_range(0, 3) == 0);
      serve(p, de);
    end

`ifdef MEM_ARB_VERIFY_EN
    // Corrupted readback during a write sets err until reset
    force0 = 1'b1;
    set_op(0, 1'b1, 2'd0, 8'h5A); serve(2'b01, 1'b0);
    force0 = 1'b0;
    chk("err_set", err, 1);
    set_op(0, 1'b0, 2'd0, 8'h00); serve(2'b01, 1'b0);
    chk("err_sticky", err, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("err_cleared", err, 0);
    rst_n = 1'b1;
    last = 1'b1;
`else
    chk("err_tied", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
